wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage, directly downstream of mem_stage in the five-stage RV32I pipeline.
- Consumes mem_stage outputs (rd addr/data/we, raw load word, funct3, opcode, ce/stall/flush).
- Extracts and sign/zero-extends load data, selects the load or ALU result, and drives the register-file write port through one registered cycle.
- Maintains a 64-bit retired-instruction counter and flags load-format errors.

Parameters:
- DWIDTH, 32, data width.
- AWIDTH, 5, register address width.
- FUNCT_WIDTH, 3, funct3 width.
- CNT_WIDTH, 64, retire counter width.

Ports:
- wb_clk  input  1  clock
- wb_rst  input  1  reset, asynchronous, active-high
- wb_i_ce  input  1  upstream instruction valid
- wb_i_stall  input  1  pipeline stall
- wb_i_flush  input  1  pipeline flush
- wb_i_opcode  input  `OPCODE_WIDTH  one-hot opcode; bit `LOAD marks a load
- wb_i_funct3  input  FUNCT_WIDTH  load size/sign
- wb_i_addr_lsb  input  2  byte offset of load address (alu_value[1:0])
- wb_i_rd_addr  input  AWIDTH  destination register
- wb_i_rd_data  input  DWIDTH  non-load result
- wb_i_rd_we  input  1  destination write request
- wb_i_load_data  input  DWIDTH  raw word-aligned memory word
- wb_o_rd_addr  output  AWIDTH  regfile write address
- wb_o_rd_data  output  DWIDTH  regfile write data / forwarding value
- wb_o_rd_we  output  1  regfile write enable, one-cycle pulse
- wb_o_ce  output  1  registered valid
- wb_o_load_err  output  1  one-cycle pulse: misaligned or illegal load
- wb_o_instret  output  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (async, wb_rst=1):
  - wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_ce, wb_o_load_err and wb_o_instret all go to 0 immediately.
  - Reset mid-instruction discards it; no write, no count.
- Accept condition: acc = wb_i_ce & ~wb_i_stall & ~wb_i_flush.
- Latency: one cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Load extraction (when wb_i_opcode[`LOAD]=1):
  - 000 LB: byte at lsb*8, sign-extended.
  - 001 LH: halfword at lsb[1]*16, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
- Load errors: misaligned (LH/LHU with lsb[0]=1; LW with lsb!=0) or funct3 in {011,110,111}.
  - On an accepted erroneous load: wb_o_load_err=1 for one cycle, wb_o_rd_we=0, wb_o_rd_data=0.
  - The instruction still counts as retired.
- Non-load instructions: wb_o_rd_data = wb_i_rd_data.
- Write enable on acc: wb_o_rd_we = wb_i_rd_we & (rd_addr!=0) & ~load_err. A write to x0 is never issued; rd_data is still registered.
- Stall (wb_i_stall=1, no flush):
  - rd_addr, rd_data and ce hold their values.
  - wb_o_rd_we and wb_o_load_err are forced to 0, so each instruction writes exactly once.
  - instret holds.
- Flush has priority over stall:
  - Next cycle: wb_o_ce=0, wb_o_rd_we=0, wb_o_load_err=0; data registers keep their old values.
  - No count.
- wb_i_ce=0 with no stall: wb_o_ce=0 and wb_o_rd_we=0 next cycle.
- Retire counter: increments by 1 on every acc, wraps from all-ones to 0. There is no other write path.
- Forwarding: wb_o_rd_data, wb_o_rd_addr and wb_o_rd_we serve as the WB forwarding source for the decoder/execute stage.

Decomposition:
- `OPCODE_WIDTH, the `LOAD index and funct3 encodings (LB..LHU) come from the shared opcode header already used by the pipeline. No new typedefs are needed.
- One combinational sub-module, wb_load_align: inputs funct3, addr_lsb and the raw word; outputs the extended data and an err flag. Reusable by a later store-side checker.
- The stage registers and the counter live in wb_stage.

Test Plan:
- ALU write: ce=1, non-load, rd=5, data=0x0000_1234, we=1 → next cycle rd_we=1, rd_addr=5, rd_data=0x1234, instret=1.
- Loads: raw word 0x80FF_7F01:
  - LB lsb=3 → 0xFFFF_FF80.
  - LBU lsb=1 → 0x0000_007F.
  - LH lsb=2 → 0xFFFF_80FF.
  - LHU lsb=0 → 0x0000_7F01.
  - LW lsb=0 → 0x80FF_7F01.
- Errors:
  - LW lsb=2 → load_err pulse, rd_we=0, rd_data=0, instret+1.
  - funct3=110 → same response.
- x0 write: rd=0, we=1 → rd_we=0, instret increments.
- Stall/flush:
  - Accept rd=7, then hold stall 3 cycles → rd_we high exactly one cycle, addr/data held, instret +1 only.
  - Flush together with stall and ce=1 → ce=0, rd_we=0, no count.
- Reset/wrap:
  - Assert wb_rst asynchronously between edges while rd_we=1 → all outputs 0 immediately.
  - Preset counter path to 2^64-1 via forced state, one acc → instret=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared opcode/funct3 definitions for the writeback stage and its load aligner.
// Opcode is one-hot; OPC_LOAD marks a memory load.
package wb_stage_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// Bus between mem_stage (master) and wb_stage (slave), plus the regfile/forwarding outputs.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int CNT_WIDTH   = 64
);
  logic                    wb_i_ce;
  logic                    wb_i_stall;
  logic                    wb_i_flush;
  logic [OPCODE_WIDTH-1:0] wb_i_opcode;
  logic [FUNCT_WIDTH-1:0]  wb_i_funct3;
  logic [1:0]              wb_i_addr_lsb;
  logic [AWIDTH-1:0]       wb_i_rd_addr;
  logic [DWIDTH-1:0]       wb_i_rd_data;
  logic                    wb_i_rd_we;
  logic [DWIDTH-1:0]       wb_i_load_data;

  logic [AWIDTH-1:0]       wb_o_rd_addr;
  logic [DWIDTH-1:0]       wb_o_rd_data;
  logic                    wb_o_rd_we;
  logic                    wb_o_ce;
  logic                    wb_o_load_err;
  logic [CNT_WIDTH-1:0]    wb_o_instret;

  modport master (
    output wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3,
           wb_i_addr_lsb, wb_i_rd_addr, wb_i_rd_data, wb_i_rd_we, wb_i_load_data,
    input  wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_ce, wb_o_load_err,
           wb_o_instret
  );

  modport slave (
    input  wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3,
           wb_i_addr_lsb, wb_i_rd_addr, wb_i_rd_data, wb_i_rd_we, wb_i_load_data,
    output wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_ce, wb_o_load_err,
           wb_o_instret
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load lane select and sign/zero extension with alignment/encoding check.
// Kept standalone so a store-side checker can reuse the same alignment rules.
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] i_funct3,
  input  logic [1:0]             i_addr_lsb,
  input  logic [DWIDTH-1:0]      i_word,
  output logic [DWIDTH-1:0]      o_data,
  output logic                   o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lsb, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lsb[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU: o_data = {{(DWIDTH-8){1'b0}}, w_byte};
      F3_LH: begin
        o_data = {{(DWIDTH-16){w_half[15]}}, w_half};
        o_err  = i_addr_lsb[0];
      end
      F3_LHU: begin
        o_data = {{(DWIDTH-16){1'b0}}, w_half};
        o_err  = i_addr_lsb[0];
      end
      F3_LW: begin
        o_data = i_word;
        o_err  = |i_addr_lsb;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects load or ALU result, drives the regfile write port one cycle later,
// and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int CNT_WIDTH   = 64
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  wb_stage_if.slave  bus
);

  logic                 w_acc;
  logic                 w_is_load;
  logic [DWIDTH-1:0]    w_load_data;
  logic                 w_align_err;
  logic                 w_load_err;
  logic [DWIDTH-1:0]    w_result;
  logic                 w_we;

  logic [AWIDTH-1:0]    r_rd_addr;
  logic [DWIDTH-1:0]    r_rd_data;
  logic                 r_rd_we;
  logic                 r_ce;
  logic                 r_load_err;
  logic [CNT_WIDTH-1:0] r_instret;

  wb_load_align #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_align (
    .i_funct3   (bus.wb_i_funct3),
    .i_addr_lsb (bus.wb_i_addr_lsb),
    .i_word     (bus.wb_i_load_data),
    .o_data     (w_load_data),
    .o_err      (w_align_err)
  );

  assign w_acc      = bus.wb_i_ce & ~bus.wb_i_stall & ~bus.wb_i_flush;
  assign w_is_load  = bus.wb_i_opcode[OPC_LOAD];
  assign w_load_err = w_is_load & w_align_err;

  // A faulting load writes zero so a stale value never reaches the forwarding path.
  assign w_result = !w_is_load ? bus.wb_i_rd_data :
                    w_load_err ? '0 : w_load_data;
  assign w_we     = bus.wb_i_rd_we & (|bus.wb_i_rd_addr) & ~w_load_err;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_rd_we    <= 1'b0;
      r_ce       <= 1'b0;
      r_load_err <= 1'b0;
      r_instret  <= '0;
    end else if (bus.wb_i_flush) begin
      r_ce       <= 1'b0;
      r_rd_we    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (bus.wb_i_stall) begin
      // Hold the payload but drop the pulses so each instruction writes once.
      r_rd_we    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (w_acc) begin
      r_rd_addr  <= bus.wb_i_rd_addr;
      r_rd_data  <= w_result;
      r_rd_we    <= w_we;
      r_ce       <= 1'b1;
      r_load_err <= w_load_err;
      r_instret  <= r_instret + CNT_WIDTH'(1);
    end else begin
      r_ce       <= 1'b0;
      r_rd_we    <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign bus.wb_o_rd_addr  = r_rd_addr;
  assign bus.wb_o_rd_data  = r_rd_data;
  assign bus.wb_o_rd_we    = r_rd_we;
  assign bus.wb_o_ce       = r_ce;
  assign bus.wb_o_load_err = r_load_err;
  assign bus.wb_o_instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a behavioural model checked every cycle plus literal spot checks.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic preset_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load rules in size/offset terms rather than bit slices.
  function automatic int ld_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic ld_err(input logic [2:0] f3, input logic [1:0] lsb);
    int sz = ld_size(f3);
    if (sz == 0) return 1'b1;
    return (int'(lsb) % sz) != 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] lsb,
                                         input logic [31:0] word);
    int sz = ld_size(f3);
    longint unsigned raw = longint'(word) >> (int'(lsb) * 8);
    longint unsigned mask;
    longint unsigned v;
    if (sz == 0) return 32'h0;
    mask = (64'd1 << (sz * 8)) - 1;
    v = raw & mask;
    if (f3[2] == 1'b0 && sz < 4 && v >= (mask + 1) / 2)
      v = v + (64'hFFFF_FFFF - mask);
    return v[31:0];
  endfunction

  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_we, m_ce, m_err;
  logic [63:0] m_instret;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr <= '0; m_data <= '0; m_we <= 1'b0; m_ce <= 1'b0; m_err <= 1'b0;
      m_instret <= '0;
    end else if (preset_req) begin
      m_instret <= '1;
      m_we <= 1'b0; m_err <= 1'b0; m_ce <= 1'b0;
    end else if (bus.wb_i_ce && !bus.wb_i_stall && !bus.wb_i_flush) begin
      logic is_ld, e;
      is_ld = bus.wb_i_opcode[OPC_LOAD];
      e = is_ld && ld_err(bus.wb_i_funct3, bus.wb_i_addr_lsb);
      m_ce   <= 1'b1;
      m_addr <= bus.wb_i_rd_addr;
      m_data <= !is_ld ? bus.wb_i_rd_data :
                e ? 32'h0 : ld_val(bus.wb_i_funct3, bus.wb_i_addr_lsb, bus.wb_i_load_data);
      m_we   <= bus.wb_i_rd_we && bus.wb_i_rd_addr != 0 && !e;
      m_err  <= e;
      m_instret <= m_instret + 1;
    end else begin
      m_we  <= 1'b0;
      m_err <= 1'b0;
      if (bus.wb_i_flush || !bus.wb_i_stall) m_ce <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ce",      bus.wb_o_ce,       m_ce);
      chk("m_we",      bus.wb_o_rd_we,    m_we);
      chk("m_err",     bus.wb_o_load_err, m_err);
      chk("m_addr",    bus.wb_o_rd_addr,  m_addr);
      chk("m_data",    bus.wb_o_rd_data,  m_data);
      chk("m_instret", bus.wb_o_instret,  m_instret);
    end
  end

  localparam logic [10:0] OP_ALU = 11'b1 << OPC_RTYPE;
  localparam logic [10:0] OP_LD  = 11'b1 << OPC_LOAD;
  localparam logic [31:0] WORD   = 32'h80FF_7F01;

  task automatic drive(input logic ce, input logic st, input logic fl, input logic [10:0] opc,
                       input logic [2:0] f3, input logic [1:0] lsb, input logic [4:0] rd,
                       input logic [31:0] d, input logic we);
    bus.wb_i_ce = ce; bus.wb_i_stall = st; bus.wb_i_flush = fl;
    bus.wb_i_opcode = opc; bus.wb_i_funct3 = f3; bus.wb_i_addr_lsb = lsb;
    bus.wb_i_rd_addr = rd; bus.wb_i_rd_data = d; bus.wb_i_rd_we = we;
    bus.wb_i_load_data = WORD;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ce"},   bus.wb_o_ce,       0);
    chk({tag, "_we"},   bus.wb_o_rd_we,    0);
    chk({tag, "_err"},  bus.wb_o_load_err, 0);
    chk({tag, "_addr"}, bus.wb_o_rd_addr,  0);
    chk({tag, "_data"}, bus.wb_o_rd_data,  0);
    chk({tag, "_cnt"},  bus.wb_o_instret,  0);
  endtask

  int we_hits;

  initial begin
    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h0, 0);
    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h0, 0);
    chk_zero("rst");
    rst = 1'b0;
    chk_en = 1'b1;

    drive(1, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd5, 32'h0000_1234, 1);
    chk("alu_we", bus.wb_o_rd_we, 1);
    chk("alu_addr", bus.wb_o_rd_addr, 5);
    chk("alu_data", bus.wb_o_rd_data, 32'h1234);
    chk("alu_cnt", bus.wb_o_instret, 1);

    drive(1, 0, 0, OP_LD, F3_LB, 2'd3, 5'd1, 32'hDEAD, 1);
    chk("lb3", bus.wb_o_rd_data, 32'hFFFF_FF80);
    drive(1, 0, 0, OP_LD, F3_LBU, 2'd1, 5'd2, 32'hDEAD, 1);
    chk("lbu1", bus.wb_o_rd_data, 32'h0000_007F);
    drive(1, 0, 0, OP_LD, F3_LH, 2'd2, 5'd3, 32'hDEAD, 1);
    chk("lh2", bus.wb_o_rd_data, 32'hFFFF_80FF);
    drive(1, 0, 0, OP_LD, F3_LHU, 2'd0, 5'd4, 32'hDEAD, 1);
    chk("lhu0", bus.wb_o_rd_data, 32'h0000_7F01);
    drive(1, 0, 0, OP_LD, F3_LW, 2'd0, 5'd6, 32'hDEAD, 1);
    chk("lw0", bus.wb_o_rd_data, 32'h80FF_7F01);
    chk("lw0_we", bus.wb_o_rd_we, 1);
    drive(1, 0, 0, OP_LD, F3_LB, 2'd2, 5'd6, 32'hDEAD, 1);
    chk("lb2", bus.wb_o_rd_data, 32'hFFFF_FFFF);

    drive(1, 0, 0, OP_LD, F3_LW, 2'd2, 5'd8, 32'hDEAD, 1);
    chk("lw2_err", bus.wb_o_load_err, 1);
    chk("lw2_we", bus.wb_o_rd_we, 0);
    chk("lw2_data", bus.wb_o_rd_data, 0);
    chk("lw2_cnt", bus.wb_o_instret, 8);
    drive(1, 0, 0, OP_LD, F3_LHU, 2'd1, 5'd8, 32'hDEAD, 1);
    chk("lhu1_err", bus.wb_o_load_err, 1);
    drive(1, 0, 0, OP_LD, 3'b110, 2'd0, 5'd9, 32'hDEAD, 1);
    chk("f110_err", bus.wb_o_load_err, 1);
    chk("f110_we", bus.wb_o_rd_we, 0);
    chk("f110_cnt", bus.wb_o_instret, 10);

    drive(1, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h55, 1);
    chk("x0_we", bus.wb_o_rd_we, 0);
    chk("x0_err", bus.wb_o_load_err, 0);
    chk("x0_cnt", bus.wb_o_instret, 11);

    drive(1, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd7, 32'h0000_ABCD, 1);
    we_hits = int'(bus.wb_o_rd_we);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, OP_ALU, 3'b000, 2'd0, 5'd9, 32'h1111_0000, 1);
      we_hits += int'(bus.wb_o_rd_we);
    end
    chk("stall_we_once", we_hits, 1);
    chk("stall_addr", bus.wb_o_rd_addr, 7);
    chk("stall_data", bus.wb_o_rd_data, 32'hABCD);
    chk("stall_ce", bus.wb_o_ce, 1);
    chk("stall_cnt", bus.wb_o_instret, 12);

    drive(1, 1, 1, OP_ALU, 3'b000, 2'd0, 5'd10, 32'h2222, 1);
    chk("flush_ce", bus.wb_o_ce, 0);
    chk("flush_we", bus.wb_o_rd_we, 0);
    chk("flush_data", bus.wb_o_rd_data, 32'hABCD);
    chk("flush_cnt", bus.wb_o_instret, 12);

    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd11, 32'h3333, 1);
    chk("idle_ce", bus.wb_o_ce, 0);
    chk("idle_cnt", bus.wb_o_instret, 12);

    drive(1, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd3, 32'h99, 1);
    chk("pre_rst_we", bus.wb_o_rd_we, 1);
    #2 rst = 1'b1;
    #1 chk_zero("async");
    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h0, 0);
    rst = 1'b0;

    bus.wb_i_ce = 1'b1; bus.wb_i_rd_addr = 5'd4; bus.wb_i_rd_data = 32'h77; bus.wb_i_rd_we = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_rst");

    #2 force dut.r_instret = '1;
    #1 release dut.r_instret;
    preset_req = 1'b1;
    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h0, 0);
    preset_req = 1'b0;
    chk("preset_cnt", bus.wb_o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd12, 32'h44, 1);
    chk("wrap_cnt", bus.wb_o_instret, 0);
    chk("wrap_we", bus.wb_o_rd_we, 1);

    drive(0, 0, 0, OP_ALU, 3'b000, 2'd0, 5'd0, 32'h0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
